// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
package nibble_serial_adder_pkg;
  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;
endpackage

// File: rtl/adder_4bit.sv
// Combinational 4-bit ripple-carry adder shared by the serial controller.
module adder_4bit
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                carry_in,
  output logic [NIBBLE_W-1:0] sum,
  output logic                overflow
);
  logic [NIBBLE_W:0] carry;

  assign carry[0] = carry_in;

  for (genvar gi = 0; gi < NIBBLE_W; gi++) begin : g_bit
    assign sum[gi]      = a[gi] ^ b[gi] ^ carry[gi];
    assign carry[gi+1]  = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
  end

  assign overflow = carry[NIBBLE_W];
endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle unsigned adder: feeds one nibble per clock through a single
// adder_4bit, holding the carry in a register between steps.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int NUM_NIBBLES = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [NIBBLE_W*NUM_NIBBLES-1:0] op_a,
  input  logic [NIBBLE_W*NUM_NIBBLES-1:0] op_b,
  input  logic                            carry_in,
  output logic                            busy,
  output logic                            done,
  output logic [NIBBLE_W*NUM_NIBBLES-1:0] sum,
  output logic                            overflow
);
  localparam int W     = NIBBLE_W * NUM_NIBBLES;
  localparam int IDX_W = (NUM_NIBBLES > 1) ? $clog2(NUM_NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NIBBLES - 1);

  state_t              state_reg, state_next;
  logic [IDX_W-1:0]    idx_reg;
  logic                carry_reg;
  logic [W-1:0]        a_reg, b_reg, sum_reg;
  logic                overflow_reg;

  logic [NIBBLE_W-1:0] add_a, add_b, add_sum;
  logic                add_carry;

  // Explicit compare-mux keeps the nibble select in range for any NUM_NIBBLES.
  always_comb begin
    add_a = '0;
    add_b = '0;
    for (int i = 0; i < NUM_NIBBLES; i++) begin
      if (idx_reg == IDX_W'(i)) begin
        add_a = a_reg[i*NIBBLE_W +: NIBBLE_W];
        add_b = b_reg[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  adder_4bit u_adder (
    .a        (add_a),
    .b        (add_b),
    .carry_in (carry_reg),
    .sum      (add_sum),
    .overflow (add_carry)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = ADD;
      ADD:     if (idx_reg == LAST_IDX) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      carry_reg    <= 1'b0;
      a_reg        <= '0;
      b_reg        <= '0;
      sum_reg      <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg        <= op_a;
            b_reg        <= op_b;
            carry_reg    <= carry_in;
            idx_reg      <= '0;
            sum_reg      <= '0;
            overflow_reg <= 1'b0;
          end
        end
        ADD: begin
          carry_reg <= add_carry;
          idx_reg   <= idx_reg + 1'b1;
          for (int i = 0; i < NUM_NIBBLES; i++) begin
            if (idx_reg == IDX_W'(i)) sum_reg[i*NIBBLE_W +: NIBBLE_W] <= add_sum;
          end
          if (idx_reg == LAST_IDX) overflow_reg <= add_carry;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state_reg == ADD);
  assign done     = (state_reg == DONE);
  assign sum      = sum_reg;
  assign overflow = overflow_reg;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and swept checks of nibble_serial_adder at 4, 2 and 1 nibbles.
module tb_nibble_serial_adder;
  logic clk;
  logic rst;

  logic        start4, cin4, busy4, done4, ovf4;
  logic [15:0] a4, b4, sum4;
  logic        start2, cin2, busy2, done2, ovf2;
  logic [7:0]  a2, b2, sum2;
  logic        start1, cin1, busy1, done1, ovf1;
  logic [3:0]  a1, b1, sum1;

  int errors = 0;
  int checks = 0;

  nibble_serial_adder #(.NUM_NIBBLES(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .op_a(a4), .op_b(b4), .carry_in(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .overflow(ovf4)
  );
  nibble_serial_adder #(.NUM_NIBBLES(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .op_a(a2), .op_b(b2), .carry_in(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .overflow(ovf2)
  );
  nibble_serial_adder #(.NUM_NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .op_a(a1), .op_b(b1), .carry_in(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .overflow(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic cur_busy(input int n);
    case (n)
      1:       return busy1;
      2:       return busy2;
      default: return busy4;
    endcase
  endfunction

  function automatic logic cur_done(input int n);
    case (n)
      1:       return done1;
      2:       return done2;
      default: return done4;
    endcase
  endfunction

  // Runs one request on the selected instance; returns at the first IDLE cycle after done.
  task automatic do_op(input int n, input logic [15:0] a, input logic [15:0] b, input logic cin,
                       output logic [15:0] s, output logic o, output int lat, output int busy_cnt);
    case (n)
      1:       begin a1 = a[3:0]; b1 = b[3:0]; cin1 = cin; start1 = 1'b1; end
      2:       begin a2 = a[7:0]; b2 = b[7:0]; cin2 = cin; start2 = 1'b1; end
      default: begin a4 = a;      b4 = b;      cin4 = cin; start4 = 1'b1; end
    endcase
    @(posedge clk); #1;
    start1 = 1'b0; start2 = 1'b0; start4 = 1'b0;
    lat = 0;
    busy_cnt = 0;
    s = '0;
    o = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (cur_busy(n)) busy_cnt++;
      if (cur_done(n)) begin
        lat = c;
        case (n)
          1:       begin s = {12'h0, sum1}; o = ovf1; end
          2:       begin s = {8'h0, sum2};  o = ovf2; end
          default: begin s = sum4;          o = ovf4; end
        endcase
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic model_op(input int n, input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input string tag);
    logic [15:0] s, mask;
    logic        o;
    logic [16:0] full;
    int          lat, bc;
    mask = 16'hFFFF >> (16 - 4 * n);
    full = {1'b0, a & mask} + {1'b0, b & mask} + {16'h0, cin};
    do_op(n, a, b, cin, s, o, lat, bc);
    check($sformatf("%s_sum", tag), {16'h0, s}, {16'h0, full[15:0] & mask});
    check($sformatf("%s_ovf", tag), {31'h0, o}, {31'h0, full[4*n]});
    check($sformatf("%s_lat", tag), lat, n + 1);
  endtask

  task automatic directed(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic [15:0] exp_s, input logic exp_o, input string tag);
    logic [15:0] s;
    logic        o;
    int          lat, bc;
    do_op(4, a, b, cin, s, o, lat, bc);
    check($sformatf("%s_sum", tag), {16'h0, s}, {16'h0, exp_s});
    check($sformatf("%s_ovf", tag), {31'h0, o}, {31'h0, exp_o});
    check($sformatf("%s_lat", tag), lat, 5);
    check($sformatf("%s_busy", tag), bc, 4);
    $display("op %s: %h + %h + %0d -> sum=%h ovf=%0d lat=%0d busy=%0d", tag, a, b, cin, s, o, lat, bc);
  endtask

  initial begin
    int ndone, last_done;
    logic [15:0] held_s;
    logic        held_o;

    start4 = 0; a4 = 0; b4 = 0; cin4 = 0;
    start2 = 0; a2 = 0; b2 = 0; cin2 = 0;
    start1 = 0; a1 = 0; b1 = 0; cin1 = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'h0, busy4}, 0);
    check("rst_done", {31'h0, done4}, 0);
    check("rst_sum", {16'h0, sum4}, 0);
    check("rst_ovf", {31'h0, ovf4}, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    directed(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, "basic");
    directed(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, "ripple");
    directed(16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, "cin");
    check("hold_sum", {16'h0, sum4}, 32'h1000);
    check("hold_done", {31'h0, done4}, 0);

    // Second request during cycle 2 must be dropped.
    a4 = 16'h1111; b4 = 16'h2222; cin4 = 0; start4 = 1;
    @(posedge clk); #1;
    start4 = 0;
    @(posedge clk); #1;
    a4 = 16'h0F0F; b4 = 16'h0101; start4 = 1;
    @(posedge clk); #1;
    start4 = 0;
    ndone = 0;
    held_s = '0;
    held_o = 1'b1;
    for (int c = 3; c <= 14; c++) begin
      if (done4) begin ndone++; held_s = sum4; held_o = ovf4; end
      @(posedge clk); #1;
    end
    check("drop_ndone", ndone, 1);
    check("drop_sum", {16'h0, held_s}, 32'h3333);
    check("drop_ovf", {31'h0, held_o}, 0);
    $display("op drop: dones=%0d sum=%h ovf=%0d", ndone, held_s, held_o);

    // Asynchronous reset in cycle 2, away from any clock edge.
    a4 = 16'h1234; b4 = 16'h1111; cin4 = 0; start4 = 1;
    @(posedge clk); #1;
    start4 = 0;
    @(posedge clk); #1;
    check("abort_busy_pre", {31'h0, busy4}, 1);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", {31'h0, busy4}, 0);
    check("abort_done", {31'h0, done4}, 0);
    check("abort_sum", {16'h0, sum4}, 0);
    check("abort_ovf", {31'h0, ovf4}, 0);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (done4) ndone++;
    end
    check("abort_nodone", ndone, 0);
    $display("op abort: dones after reset=%0d", ndone);
    directed(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, "post_rst");

    // Continuous start: done every 6 cycles, in-flight operands tampered with.
    a4 = 16'h8000; b4 = 16'h8000; cin4 = 0; start4 = 1;
    ndone = 0;
    last_done = 0;
    for (int c = 1; c <= 19; c++) begin
      @(posedge clk); #1;
      if (done4) begin
        ndone++;
        check("stream_sum", {16'h0, sum4}, 0);
        check("stream_ovf", {31'h0, ovf4}, 1);
        if (last_done == 0) check("stream_first", c, 5);
        else check("stream_gap", c - last_done, 6);
        $display("op stream: done in cycle %0d sum=%h ovf=%0d", c, sum4, ovf4);
        last_done = c;
      end
      if (c % 6 == 2) begin a4 = 16'hFFFF; b4 = 16'h7FFF; cin4 = 1; end
      if (c % 6 == 4) begin a4 = 16'h8000; b4 = 16'h8000; cin4 = 0; end
    end
    start4 = 0;
    check("stream_ndone", ndone, 3);
    repeat (10) @(posedge clk);
    #1;

    for (int i = 0; i < 2000; i++)
      model_op(4, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
               1'($urandom_range(0, 1)), "n4");
    $display("sweep n4: 2000 random operations done");
    for (int i = 0; i < 2000; i++)
      model_op(2, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)),
               1'($urandom_range(0, 1)), "n2");
    $display("sweep n2: 2000 random operations done");
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      model_op(1, {12'h0, v[3:0]}, {12'h0, v[7:4]}, v[8], "n1");
    end
    $display("sweep n1: 512 exhaustive operations done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle unsigned adder controller. It sequences the team's combinational 4-bit ripple adder (`adder_4bit`) one nibble per clock to add two `4*NUM_NIBBLES`-bit operands. Carry is held in a register between nibble steps, and completion is signalled with a start/busy/done handshake. It sits between a requesting datapath and the single shared `adder_4bit` instance, trading latency for area.

## Interface
- `NUM_NIBBLES`, default 4: operand width in nibbles. Operand width W = 4*NUM_NIBBLES. Legal range 1..16.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous and active-high.
- `start`  in  1  request; sampled only in IDLE.
- `op_a`  in  W  operand A; captured on the accepting edge.
- `op_b`  in  W  operand B; captured on the accepting edge.
- `carry_in`  in  1  initial carry; captured on the accepting edge.
- `busy`  out  1  high while nibble steps are in progress (ADD state).
- `done`  out  1  one-cycle pulse; `sum` and `overflow` are valid.
- `sum`  out  W  result, registered.
- `overflow`  out  1  carry out of the most significant nibble (unsigned overflow), registered.

## Operation
- States: IDLE, ADD, DONE.
- **IDLE:** `busy`=0, `done`=0. On an edge with `start`=1:
  - latch `op_a`, `op_b`, and `carry_in` into the carry register;
  - set nibble index `idx` to 0;
  - clear `sum`;
  - go to ADD.
- **ADD:**
  - The adder receives `a` = A[4*idx+3 : 4*idx], `b` = B[same slice], and `carry_in` = carry register.
  - Each edge writes adder `sum` into `sum`[4*idx+3 : 4*idx], loads adder `overflow` into the carry register, and increments `idx`.
  - When `idx` = NUM_NIBBLES-1, the same edge copies the new carry into `overflow` and goes to DONE.
- **DONE:** `done`=1 and `busy`=0 for exactly one cycle, then unconditionally go to IDLE.
- `start` is ignored in ADD and DONE. There is no queueing; a request seen outside IDLE is dropped.
- `sum` and `overflow` hold their values from DONE until the next accepted start. On that edge `sum` clears and `overflow` clears.
- Arithmetic: {`overflow`, `sum`} = A + B + `carry_in`, computed modulo 2^(W+1), with no truncation.
- Latched operands are unaffected by changes to `op_a`, `op_b` or `carry_in` after acceptance.

## Timing
- Reset values, applied immediately when `rst` asserts (no clock needed):
  - state IDLE, `idx`=0, carry register 0;
  - `busy`=0, `done`=0, `sum`=0, `overflow`=0.
- Reset asserted during ADD or DONE aborts the operation. No `done` pulse is issued for the aborted request.
- Cycle numbering:
  - Accepting edge E0 starts cycle 1.
  - `busy`=1 in cycles 1..NUM_NIBBLES.
  - `done`=1 in cycle NUM_NIBBLES+1.
  - Back in IDLE in cycle NUM_NIBBLES+2.
- Latency: for default NUM_NIBBLES=4, `done` is high in the 5th cycle after the accepting edge.
- Throughput: with `start` held high continuously, a new request is accepted every NUM_NIBBLES+2 cycles. `done` pulses are 6 cycles apart for the default width.
- NUM_NIBBLES=1: ADD lasts one cycle, and `done` is high in cycle 2.
- The only combinational path through the shared adder is from the state/operand registers to the `sum` and carry registers. No output is combinational from inputs.

## Structure
- Package `nibble_serial_adder_pkg` holds:
  - the state typedef, an enum {IDLE, ADD, DONE};
  - `NIBBLE_W` = 4.
- The single sub-module is the existing `adder_4bit`, instantiated once, with ports `a`, `b`, `carry_in`, `sum`, `overflow`.
- The controller is organised as:
  - a state register with next-state logic;
  - an `idx` counter of width $clog2(NUM_NIBBLES), minimum 1 bit;
  - the carry register;
  - the operand and result registers.

## Test plan
- `op_a`=0x1234, `op_b`=0x4321, `carry_in`=0, pulse `start` -> `busy` high for 4 cycles; `done` in cycle 5 with `sum`=0x5555, `overflow`=0.
- 0xFFFF + 0x0001, `carry_in`=0 -> carry ripples through all 4 nibbles; `sum`=0x0000, `overflow`=1. Also 0x0FFF + 0x0000 with `carry_in`=1 -> `sum`=0x1000, `overflow`=0.
- Pulse `start` again in cycle 2 of an operation with different operands -> the second request is ignored; exactly one `done`, carrying the first result.
- Assert `rst` mid-operation (cycle 2), asynchronous to `clk` -> all outputs 0 immediately and no `done`. After release, 0x00FF + 0x0001 -> `sum`=0x0100.
- Hold `start` high with 0x8000 + 0x8000 -> `done` pulses 6 cycles apart, each with `sum`=0x0000, `overflow`=1. Operands changed after acceptance do not alter the in-flight result.
- Randomised sweep of 2000 operand/carry triples, checked against the `op_a + op_b + carry_in` reference model. Repeat with NUM_NIBBLES=1 and 2, including exhaustive coverage of the 9-bit input space at NUM_NIBBLES=1.
